// File: rtl/ps2_letter_decoder.sv
// PS/2 keyboard receiver that turns A-Z and Enter make-codes into one-cycle pulses
// with a 5-bit letter code (A=1 .. Z=26, 0 = no letter).
module ps2_letter_decoder #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic [4:0] char_o,
    output logic       letter_valid_o,
    output logic       enter_pulse_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    localparam int unsigned FLT_W  = $clog2(FILTER_LEN + 1);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CODE_W = 5;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

    logic [1:0]       clk_sync_q, dat_sync_q;
    logic             clk_flt_q, dat_flt_q, clk_prev_q;
    logic [FLT_W-1:0] clk_fcnt_q, dat_fcnt_q;
    logic             fall_c;

    state_e            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              par_q, par_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              brk_q, brk_d, ext_q, ext_d;
    logic [CODE_W-1:0] char_q, char_d, code_c;
    logic              lv_q, lv_d, en_q, en_d, fe_q, fe_d, busy_q, busy_d;

    // Scancode set 2 make-code to letter number
    function automatic logic [CODE_W-1:0] letter_code(input logic [7:0] sc);
        case (sc)
            8'h1C: letter_code = 5'd1;   8'h32: letter_code = 5'd2;
            8'h21: letter_code = 5'd3;   8'h23: letter_code = 5'd4;
            8'h24: letter_code = 5'd5;   8'h2B: letter_code = 5'd6;
            8'h34: letter_code = 5'd7;   8'h33: letter_code = 5'd8;
            8'h43: letter_code = 5'd9;   8'h3B: letter_code = 5'd10;
            8'h42: letter_code = 5'd11;  8'h4B: letter_code = 5'd12;
            8'h3A: letter_code = 5'd13;  8'h31: letter_code = 5'd14;
            8'h44: letter_code = 5'd15;  8'h4D: letter_code = 5'd16;
            8'h15: letter_code = 5'd17;  8'h2D: letter_code = 5'd18;
            8'h1B: letter_code = 5'd19;  8'h2C: letter_code = 5'd20;
            8'h3C: letter_code = 5'd21;  8'h2A: letter_code = 5'd22;
            8'h1D: letter_code = 5'd23;  8'h22: letter_code = 5'd24;
            8'h35: letter_code = 5'd25;  8'h1A: letter_code = 5'd26;
            default: letter_code = 5'd0;
        endcase
    endfunction

    // Synchronizers and glitch filters; idle PS/2 lines are high
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_flt_q  <= 1'b1;
            dat_flt_q  <= 1'b1;
            clk_prev_q <= 1'b1;
            clk_fcnt_q <= '0;
            dat_fcnt_q <= '0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
            clk_prev_q <= clk_flt_q;
            if (clk_sync_q[1] == clk_flt_q) begin
                clk_fcnt_q <= '0;
            end else if (clk_fcnt_q == FLT_W'(FILTER_LEN - 1)) begin
                clk_flt_q  <= clk_sync_q[1];
                clk_fcnt_q <= '0;
            end else begin
                clk_fcnt_q <= clk_fcnt_q + FLT_W'(1);
            end
            if (dat_sync_q[1] == dat_flt_q) begin
                dat_fcnt_q <= '0;
            end else if (dat_fcnt_q == FLT_W'(FILTER_LEN - 1)) begin
                dat_flt_q  <= dat_sync_q[1];
                dat_fcnt_q <= '0;
            end else begin
                dat_fcnt_q <= dat_fcnt_q + FLT_W'(1);
            end
        end
    end

    assign fall_c = clk_prev_q & ~clk_flt_q;
    assign code_c = letter_code(shift_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tmo_q     <= '0;
            brk_q     <= 1'b0;
            ext_q     <= 1'b0;
            char_q    <= '0;
            lv_q      <= 1'b0;
            en_q      <= 1'b0;
            fe_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tmo_q     <= tmo_d;
            brk_q     <= brk_d;
            ext_q     <= ext_d;
            char_q    <= char_d;
            lv_q      <= lv_d;
            en_q      <= en_d;
            fe_q      <= fe_d;
            busy_q    <= busy_d;
        end
    end

    // Frame receive, byte interpretation and mid-frame timeout
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tmo_d     = tmo_q;
        brk_d     = brk_q;
        ext_d     = ext_q;
        char_d    = char_q;
        lv_d      = 1'b0;
        en_d      = 1'b0;
        fe_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                if (fall_c && !dat_flt_q) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (fall_c) begin
                    shift_d[bit_cnt_q] = dat_flt_q;
                    bit_cnt_d          = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                end
            end
            S_PARITY: begin
                if (fall_c) begin
                    par_d   = dat_flt_q;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (fall_c) begin
                    state_d = S_IDLE;
                    if (dat_flt_q && (^{shift_q, par_q})) begin
                        if (shift_q == 8'hF0) begin
                            brk_d = 1'b1;
                        end else if (shift_q == 8'hE0) begin
                            ext_d = 1'b1;
                        end else if (brk_q || ext_q) begin
                            brk_d = 1'b0;
                            ext_d = 1'b0;
                        end else if (code_c != '0) begin
                            char_d = code_c;
                            lv_d   = 1'b1;
                        end else if (shift_q == 8'h5A) begin
                            en_d = 1'b1;
                        end
                    end else begin
                        fe_d  = 1'b1;
                        brk_d = 1'b0;
                        ext_d = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_q != S_IDLE) begin
            if (fall_c) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                state_d = S_IDLE;
                tmo_d   = '0;
                fe_d    = 1'b1;
                brk_d   = 1'b0;
                ext_d   = 1'b0;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
        busy_d = (state_d != S_IDLE);
    end

    assign char_o         = char_q;
    assign letter_valid_o = lv_q;
    assign enter_pulse_o  = en_q;
    assign frame_err_o    = fe_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_ps2_letter_decoder.sv
// Directed bench for ps2_letter_decoder: drives PS/2 frames bit by bit and checks
// pulses, letter codes, latencies, timeout and reset behaviour.
module tb_ps2_letter_decoder;

    localparam int unsigned FILTER_LEN     = 4;
    localparam int unsigned TIMEOUT_CYCLES = 2000;
    localparam int unsigned HALF           = 100;
    localparam int          PIPE_LAT       = 7;

    logic       clk = 1'b0;
    logic       resetn;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [4:0] char_o;
    logic       letter_valid_o, enter_pulse_o, frame_err_o, busy_o;

    ps2_letter_decoder #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .ps2_clk_i     (ps2_clk),
        .ps2_dat_i     (ps2_dat),
        .char_o        (char_o),
        .letter_valid_o(letter_valid_o),
        .enter_pulse_o (enter_pulse_o),
        .frame_err_o   (frame_err_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_cmp = 0, n_err = 0;
    int   lv_cnt = 0, en_cnt = 0, fe_cnt = 0, ovl_cnt = 0, wide_cnt = 0;
    int   lv_cyc = 0, fe_cyc = 0, last_fall = 0;
    logic lv_prev = 1'b0, en_prev = 1'b0, fe_prev = 1'b0;
    logic mid_busy;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor sampled away from the active edge
    always @(negedge clk) begin
        if (letter_valid_o === 1'b1) begin
            lv_cnt <= lv_cnt + 1;
            lv_cyc <= cyc;
        end
        if (enter_pulse_o === 1'b1) en_cnt <= en_cnt + 1;
        if (frame_err_o === 1'b1) begin
            fe_cnt <= fe_cnt + 1;
            fe_cyc <= cyc;
        end
        if (int'(letter_valid_o) + int'(enter_pulse_o) + int'(frame_err_o) > 1)
            ovl_cnt <= ovl_cnt + 1;
        if ((letter_valid_o && lv_prev) || (enter_pulse_o && en_prev) || (frame_err_o && fe_prev))
            wide_cnt <= wide_cnt + 1;
        lv_prev <= letter_valid_o;
        en_prev <= enter_pulse_o;
        fe_prev <= frame_err_o;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One PS/2 bit: data changes mid-high, then a low and a high half-period
    task automatic ps2_bit(input logic b);
        wait_clks(int'(HALF / 2));
        ps2_dat = b;
        wait_clks(int'(HALF / 2));
        ps2_clk   = 1'b0;
        last_fall = cyc;
        wait_clks(int'(HALF));
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip_par);
        logic par;
        par = (~^b) ^ flip_par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            ps2_bit(b[i]);
            if (i == 3) mid_busy = busy_o;
        end
        ps2_bit(par);
        ps2_bit(1'b1);
        wait_clks(int'(HALF));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lv0, en0, fe0, t0;
        logic [7:0] b;
        resetn  = 1'b0;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        wait_clks(5);
        check_val("rst_char", 32'(char_o), 32'd0);
        check_val("rst_lv", 32'(letter_valid_o), 32'd0);
        check_val("rst_en", 32'(enter_pulse_o), 32'd0);
        check_val("rst_fe", 32'(frame_err_o), 32'd0);
        check_val("rst_busy", 32'(busy_o), 32'd0);
        resetn = 1'b1;
        wait_clks(20);

        // Single letter A
        lv0 = lv_cnt; fe0 = fe_cnt;
        send_frame(8'h1C, 1'b0);
        check_val("a_lv_cnt", 32'(lv_cnt - lv0), 32'd1);
        check_val("a_char", 32'(char_o), 32'd1);
        check_val("a_latency", 32'(lv_cyc - last_fall), 32'(PIPE_LAT));
        check_val("a_mid_busy", 32'(mid_busy), 32'd1);
        check_val("a_busy_after", 32'(busy_o), 32'd0);
        check_val("a_no_fe", 32'(fe_cnt - fe0), 32'd0);

        // Z make, break, Z
        lv0 = lv_cnt; en0 = en_cnt;
        send_frame(8'h1A, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1A, 1'b0);
        check_val("z_lv_cnt", 32'(lv_cnt - lv0), 32'd1);
        check_val("z_char", 32'(char_o), 32'd26);
        check_val("z_no_en", 32'(en_cnt - en0), 32'd0);

        // Parity error then a good T
        lv0 = lv_cnt; fe0 = fe_cnt;
        send_frame(8'h35, 1'b1);
        check_val("par_fe_cnt", 32'(fe_cnt - fe0), 32'd1);
        check_val("par_fe_lat", 32'(fe_cyc - last_fall), 32'(PIPE_LAT));
        check_val("par_no_lv", 32'(lv_cnt - lv0), 32'd0);
        check_val("par_char_kept", 32'(char_o), 32'd26);
        send_frame(8'h2C, 1'b0);
        check_val("t_char", 32'(char_o), 32'd20);
        check_val("t_lv_cnt", 32'(lv_cnt - lv0), 32'd1);

        // Keypad Enter suppressed, plain Enter pulses
        lv0 = lv_cnt; en0 = en_cnt;
        send_frame(8'hE0, 1'b0);
        send_frame(8'h5A, 1'b0);
        check_val("kp_no_en", 32'(en_cnt - en0), 32'd0);
        check_val("kp_no_lv", 32'(lv_cnt - lv0), 32'd0);
        send_frame(8'h5A, 1'b0);
        check_val("ent_cnt", 32'(en_cnt - en0), 32'd1);
        check_val("ent_char", 32'(char_o), 32'd20);
        check_val("ent_no_lv", 32'(lv_cnt - lv0), 32'd0);

        // Truncated frame: timeout
        b = 8'h24;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(b[i]);
        t0 = last_fall;
        for (int k = 0; k < 3000; k++) begin
            wait_clks(1);
            if (frame_err_o) break;
        end
        check_val("tmo_seen", 32'(frame_err_o), 32'd1);
        check_val("tmo_latency", 32'(cyc - t0), 32'(int'(TIMEOUT_CYCLES) + PIPE_LAT));
        check_val("tmo_busy", 32'(busy_o), 32'd0);
        send_frame(8'h24, 1'b0);
        check_val("e_char", 32'(char_o), 32'd5);

        // Short glitch on ps2_clk with data low must not start a frame
        lv0 = lv_cnt; fe0 = fe_cnt;
        wait_clks(int'(HALF / 2));
        ps2_dat = 1'b0;
        wait_clks(int'(HALF / 2));
        ps2_clk = 1'b0;
        wait_clks(2);
        ps2_clk = 1'b1;
        wait_clks(20);
        check_val("gl_busy", 32'(busy_o), 32'd0);
        wait_clks(30);
        ps2_dat = 1'b1;
        wait_clks(int'(HALF));
        check_val("gl_no_pulse", 32'(lv_cnt - lv0 + fe_cnt - fe0), 32'd0);

        // Reset mid-frame, then a full I
        fe0 = fe_cnt;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        check_val("rm_busy_before", 32'(busy_o), 32'd1);
        resetn = 1'b0;
        #1;
        check_val("rm_char", 32'(char_o), 32'd0);
        check_val("rm_busy", 32'(busy_o), 32'd0);
        check_val("rm_pulses", 32'(int'(letter_valid_o) + int'(enter_pulse_o) + int'(frame_err_o)), 32'd0);
        wait_clks(5);
        resetn  = 1'b1;
        ps2_dat = 1'b1;
        wait_clks(20);
        lv0 = lv_cnt;
        send_frame(8'h43, 1'b0);
        check_val("i_char", 32'(char_o), 32'd9);
        check_val("i_lv_cnt", 32'(lv_cnt - lv0), 32'd1);
        check_val("i_no_fe", 32'(fe_cnt - fe0), 32'd0);

        check_val("pulse_overlap", 32'(ovl_cnt), 32'd0);
        check_val("pulse_width", 32'(wide_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
